// File: rtl/uart_receiver.sv
// 8N1 UART receive front end: two-flop synchroniser, mid-bit sampling FSM,
// start-glitch rejection, stop-bit framing check and a break hold state.
module uart_receiver #(
  parameter int CLK_FREQ     = 27000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_rx,
  output logic [7:0] out_data,
  output logic       out_data_en,
  output logic       out_frame_err,
  output logic       out_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          data_en_q, data_en_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;

  // Synchroniser flops reset high so a reset never looks like a start edge.
  always_comb begin
    rx_meta_d = in_rx;
    rx_s_d    = rx_meta_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    data_en_d   = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          // Line back high at the start-bit centre means it was a glitch.
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d    = shift_q;
            data_en_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      data_en_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      data_en_q   <= data_en_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign out_data      = data_q;
  assign out_data_en   = data_en_q;
  assign out_frame_err = frame_err_q;
  assign out_busy      = busy_q;

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART receive front end that turns the serial `uart_rx` pin into `uart_data[7:0]` plus a one-cycle valid strobe (`u_data_en`).
- Output feeds the memory stage's `in_uart` / `in_uart_en` inputs.
- Frame format: 8N1 (1 start, 8 data bits LSB first, no parity, 1 stop).
- Mid-bit sampling off a clock-divided bit counter, with start-bit glitch rejection, stop-bit framing check and a status strobe.

Parameters:
- CLK_FREQ, 27000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 234 at defaults), clocks per bit; must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (117 at defaults), clocks from start-edge detection to the start-bit sample.

Ports:
- in_clk  input  1  system clock; all logic is on the rising edge.
- in_rst  input  1  synchronous, active-high reset.
- in_rx  input  1  asynchronous serial line; idle high.
- out_data  output  8  last correctly framed byte; held until the next good frame.
- out_data_en  output  1  one-cycle strobe: out_data was updated on this edge.
- out_frame_err  output  1  one-cycle strobe: stop bit was sampled low.
- out_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- One clock: in_clk. Reset is synchronous and active-high on in_rst; nothing is reset asynchronously.
- Reset values:
  - out_data = 8'h00; out_data_en = 0; out_frame_err = 0; out_busy = 0.
  - FSM = IDLE; bit counter = 0; bit index = 0; shift register = 0.
  - Both synchroniser flops = 1.
- Input synchroniser: in_rx passes through 2 flops (rx_s). The FSM uses rx_s only, so it sees the line 2 cycles late.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rx_s==0, go to START with cnt=0.
  - START: cnt increments each cycle. At cnt==HALF_BIT-1:
    - rx_s==0: go to DATA with cnt=0, idx=0.
    - rx_s==1: glitch; return to IDLE with no output activity.
  - DATA: cnt runs 0..CLKS_PER_BIT-1, then wraps to 0. At cnt==CLKS_PER_BIT-1:
    - shift = {rx_s, shift[7:1]} (LSB first).
    - idx increments; after the sample with idx==7, go to STOP.
  - STOP: at cnt==CLKS_PER_BIT-1:
    - rx_s==1: out_data <= shift, out_data_en <= 1 for exactly one cycle, go to IDLE.
    - rx_s==0: out_frame_err <= 1 for one cycle, out_data unchanged, no out_data_en, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. A held-low line therefore produces exactly one frame_err and no repeated frames.
- Latency: out_data_en goes high exactly HALF_BIT + 9*CLKS_PER_BIT cycles after the first START cycle. The first START cycle is 3 cycles after in_rx falls (2 synchroniser + 1 IDLE detect). Total at defaults: 2226 cycles after the in_rx falling edge.
- Sample points fall at bit centres. At defaults, tolerance is about ±4% combined baud mismatch.
- Back-to-back frames:
  - A start edge arriving the cycle after the STOP sample is accepted, so there is no dead time beyond the stop bit's second half.
  - IDLE is re-entered before that edge can be seen.
- out_data_en and out_frame_err are never high on the same cycle.
- out_busy = (state != IDLE), registered alongside the state.
- Reset mid-frame: partial byte discarded, no strobe, state returns to IDLE.
  - If the line is low when reset is released, the synchroniser first shows 1 for 2 cycles.
  - A still-low line then starts a frame. That frame is accepted, or ends in frame_err/BREAK.
- Counter width: $clog2(CLKS_PER_BIT). Index width: 3 bits. No arithmetic overflow is possible; cnt is cleared on every wrap and state change.

Test Plan:
- Defaults; reset for 5 cycles, then send 8N1 byte 0x3F at exactly 115200 baud (234 clk/bit) -> out_data=0x3F; out_data_en high for 1 cycle, 2226 cycles after the start edge; out_frame_err stays 0; out_busy falls the same cycle.
- Back-to-back 0xA5 then 0x5A with zero idle between stop and next start -> two strobes 2340 cycles apart; values 0xA5 then 0x5A; no frame_err.
- Send 0x55 with stop bit driven low, then hold low 1000 cycles, then high -> one out_frame_err pulse, no out_data_en, out_data keeps the previous 0x5A, out_busy stays high until rx returns high. A following clean 0x01 is received correctly.
- Low glitch of 50 cycles on idle line -> out_busy high for about 117 cycles, then low; no strobe of either kind.
- Assert in_rst for 1 cycle at mid-bit 4 of byte 0xF0 -> all outputs 0 the next cycle, no strobe from the aborted frame; the subsequent clean 0x12 gives out_data=0x12.
- Send 0xC3 at +3% and at -3% baud (227 and 241 clk/bit) -> out_data=0xC3 both times, no frame_err.
